// File: rtl/ahb_sram.sv
// ahb_sram: AHB-Lite slave memory with byte-lane writes, HSIZE-aware
// alignment checks, configurable wait states and a two-cycle ERROR response.
// Storage is little-endian 64-bit dwords; contents survive reset.
module ahb_sram #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [63:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [63:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA
);

    localparam int unsigned DWORDS    = DEPTH_BYTES / 8;
    localparam int          AW        = (DWORDS > 1) ? $clog2(DWORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state;
    state_t          stateNext;
    state_t          startState;
    logic [3:0]      waitCnt;
    logic [AW-1:0]   idxQ;
    logic [2:0]      laneQ;
    logic [1:0]      sizeQ;
    logic            writeQ;
    logic [63:0]     offset;
    logic            active;
    logic            canAccept;
    logic            acceptNow;
    logic            misalign;
    logic            rangeBad;
    logic            illegal;
    logic [7:0]      laneEn;
    logic [63:0]     mem [DWORDS];

    // Decode the address phase: is it a real transfer, may we take it, and is it legal.
    always_comb begin
        offset    = HADDR - BASE_ADDR;
        active    = (HTRANS == 2'b10) || (HTRANS == 2'b11);
        canAccept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
        acceptNow = HSEL && active && HREADY && canAccept;
        misalign  = 1'b0;
        case (HSIZE)
            3'd1:    misalign = HADDR[0];
            3'd2:    misalign = |HADDR[1:0];
            3'd3:    misalign = |HADDR[2:0];
            default: misalign = 1'b0;
        endcase
        rangeBad = (HADDR < BASE_ADDR) || (offset >= 64'(DEPTH_BYTES));
        illegal  = HSIZE[2] || misalign || rangeBad;
        if (illegal) begin
            startState = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
            startState = ST_DONE;
        end else begin
            startState = ST_WAIT;
        end
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Wait counter and the latched address-phase controls of the pending transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            waitCnt <= 4'd0;
            writeQ  <= 1'b0;
            idxQ    <= '0;
            laneQ   <= 3'd0;
            sizeQ   <= 2'd0;
        end else begin
            if (acceptNow) begin
                idxQ   <= offset[AW+2:3];
                laneQ  <= offset[2:0];
                sizeQ  <= HSIZE[1:0];
                writeQ <= HWRITE;
            end
            if (acceptNow && !illegal) begin
                waitCnt <= WAIT_INIT;
            end else if (state == ST_WAIT && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
        end
    end

    // Next-state logic plus the bus response and read data for the current data phase.
    always_comb begin
        stateNext = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 64'h0;
        case (state)
            ST_IDLE: begin
                if (acceptNow) stateNext = startState;
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (waitCnt == 4'd1) stateNext = ST_DONE;
            end
            ST_DONE: begin
                if (!writeQ) HRDATA = mem[idxQ];
                stateNext = acceptNow ? startState : ST_IDLE;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                stateNext = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
                stateNext = acceptNow ? startState : ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Byte lanes covered by the pending transfer, starting at its byte offset in the dword.
    always_comb begin
        laneEn = 8'h00;
        for (int k = 0; k < 8; k++) begin
            laneEn[k] = (4'(k) >= {1'b0, laneQ}) &&
                        (4'(k) < ({1'b0, laneQ} + (4'd1 << sizeQ)));
        end
    end

    // Commit write lanes on the edge that closes the DONE cycle; reset drops the write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == ST_DONE && writeQ) begin
            for (int k = 0; k < 8; k++) begin
                if (laneEn[k]) mem[idxQ][8*k +: 8] <= HWDATA[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram.sv
// tb_ahb_sram: directed bench for ahb_sram with a scoreboard of expected data-phase
// responses. Unit 0 is zero-wait at a non-zero base, unit 1 has two wait states.
module tb_ahb_sram;

    localparam logic [63:0] BASE0  = 64'h1000;
    localparam int unsigned DEPTH0 = 256;
    localparam logic [63:0] BASE1  = 64'h0;
    localparam int unsigned DEPTH1 = 64;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sel0;
    logic        sel1;
    logic [63:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [63:0] hwdata;
    logic        ready0;
    logic        resp0;
    logic [63:0] rdata0;
    logic        ready1;
    logic        resp1;
    logic [63:0] rdata1;

    typedef struct {
        string       tag;
        logic        isRead;
        logic        resp;
        logic [63:0] data;
        int          waits;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram #(.DEPTH_BYTES(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(0)) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ready0),
        .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_sram #(.DEPTH_BYTES(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(2)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(ready1),
        .HREADYOUT(ready1), .HRESP(resp1), .HRDATA(rdata1)
    );

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one address phase, record its expected response, hold it until accepted.
    task automatic applyStimulus(input int unit, input logic wr, input logic [2:0] size,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic expResp, input logic [63:0] expData,
                                 input int waits, input string tag);
        exp_t e;
        logic rdy;
        logic accepted;
        e.tag = tag; e.isRead = !wr; e.resp = expResp; e.data = expData; e.waits = waits;
        sb.push_back(e);
        sel0 = (unit == 0); sel1 = (unit == 1);
        htrans = 2'b10; hwrite = wr; hsize = size; haddr = addr;
        accepted = 1'b0;
        for (int c = 0; c < 40 && !accepted; c++) begin
            @(negedge HCLK);
            rdy = (unit == 0) ? ready0 : ready1;
            @(posedge HCLK);
            accepted = rdy;
        end
        checkValue({tag, "-accepted"}, 64'(accepted), 64'd1);
        #1;
        sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00; hwdata = wdata;
    endtask

    // Follow one data phase and compare it against the oldest scoreboard entry.
    task automatic checkOutput(input int unit);
        exp_t        e;
        logic        rdy;
        logic        rsp;
        logic [63:0] dat;
        int          lowCycles;
        logic        done;
        lowCycles = 0;
        done = 1'b0;
        @(negedge HCLK);
        if (sb.size() == 0) begin
            checkValue("scoreboard-empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < 40 && !done; c++) begin
            if (c != 0) @(negedge HCLK);
            rdy = (unit == 0) ? ready0 : ready1;
            rsp = (unit == 0) ? resp0 : resp1;
            dat = (unit == 0) ? rdata0 : rdata1;
            if (!rdy) begin
                lowCycles++;
                checkValue({e.tag, "-lowresp"}, 64'(rsp), 64'(e.resp));
                checkValue({e.tag, "-lowdata"}, dat, 64'h0);
            end else begin
                done = 1'b1;
                checkValue({e.tag, "-waits"}, 64'(lowCycles), 64'(e.waits));
                checkValue({e.tag, "-resp"}, 64'(rsp), 64'(e.resp));
                if (e.resp) checkValue({e.tag, "-data"}, dat, 64'h0);
                else if (e.isRead) checkValue({e.tag, "-data"}, dat, e.data);
            end
        end
        checkValue({e.tag, "-completed"}, 64'(done), 64'd1);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESET = 1'b1; sel0 = 1'b0; sel1 = 1'b0; haddr = 64'h0; htrans = 2'b00;
        hsize = 3'd0; hwrite = 1'b0; hwdata = 64'h0;
        repeat (2) @(posedge HCLK);
        #1;
        checkValue("reset-ready0", 64'(ready0), 64'd1);
        checkValue("reset-resp0", 64'(resp0), 64'd0);
        checkValue("reset-rdata0", rdata0, 64'h0);
        checkValue("reset-ready1", 64'(ready1), 64'd1);
        checkValue("reset-resp1", 64'(resp1), 64'd0);
        checkValue("reset-rdata1", rdata1, 64'h0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Byte writes 0x11..0x88 with the byte replicated on every lane.
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'((k + 1) * 8'h11);
            applyStimulus(0, 1'b1, 3'd0, BASE0 + 64'(k), {8{b}}, 1'b0, 64'h0, 0, "byte-wr");
            checkOutput(0);
        end
        applyStimulus(0, 1'b0, 3'd3, BASE0, 64'h0, 1'b0, 64'h8877665544332211, 0, "dword-rd");
        checkOutput(0);

        // Halfword into the top lanes of an all-ones dword.
        applyStimulus(0, 1'b1, 3'd3, BASE0 + 64'd8, '1, 1'b0, 64'h0, 0, "ones-wr");
        checkOutput(0);
        applyStimulus(0, 1'b1, 3'd1, BASE0 + 64'd14, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0, 0, "half-wr");
        checkOutput(0);
        applyStimulus(0, 1'b0, 3'd3, BASE0 + 64'd8, 64'h0, 1'b0, 64'hBEEFFFFFFFFFFFFF, 0, "half-rd");
        checkOutput(0);

        // Illegal transfers: misaligned, bad size, past the end, below the base.
        applyStimulus(0, 1'b1, 3'd1, BASE0 + 64'd3, '1, 1'b1, 64'h0, 1, "err-misalign");
        checkOutput(0);
        applyStimulus(0, 1'b1, 3'b100, BASE0, '1, 1'b1, 64'h0, 1, "err-size");
        checkOutput(0);
        applyStimulus(0, 1'b1, 3'd3, BASE0 + 64'(DEPTH0), '1, 1'b1, 64'h0, 1, "err-range");
        checkOutput(0);
        applyStimulus(0, 1'b0, 3'd3, BASE0 - 64'd8, 64'h0, 1'b1, 64'h0, 1, "err-below");
        checkOutput(0);
        applyStimulus(0, 1'b0, 3'd2, BASE0 + 64'd2, 64'h0, 1'b1, 64'h0, 1, "err-word-rd");
        checkOutput(0);
        applyStimulus(0, 1'b0, 3'd3, BASE0, 64'h0, 1'b0, 64'h8877665544332211, 0, "after-err-rd");
        checkOutput(0);

        // BUSY while selected, then NONSEQ while unselected: neither is a transfer.
        haddr = BASE0; hsize = 3'd3; hwrite = 1'b0;
        sel0 = 1'b1; htrans = 2'b01;
        @(posedge HCLK);
        #1;
        sel0 = 1'b0; htrans = 2'b10;
        @(negedge HCLK);
        checkValue("busy-ready", 64'(ready0), 64'd1);
        checkValue("busy-rdata", rdata0, 64'h0);
        @(posedge HCLK);
        #1;
        htrans = 2'b00;
        @(negedge HCLK);
        checkValue("unsel-ready", 64'(ready0), 64'd1);
        checkValue("unsel-rdata", rdata0, 64'h0);
        @(posedge HCLK);
        #1;

        // Two wait states: write, read back, then pipelined write-then-read.
        applyStimulus(1, 1'b1, 3'd3, BASE1 + 64'h10, 64'h0123456789ABCDEF, 1'b0, 64'h0, 2, "ws-wr");
        checkOutput(1);
        applyStimulus(1, 1'b0, 3'd3, BASE1 + 64'h10, 64'h0, 1'b0, 64'h0123456789ABCDEF, 2, "ws-rd");
        checkOutput(1);
        fork
            begin
                applyStimulus(1, 1'b1, 3'd3, BASE1 + 64'h10, 64'hCAFEF00DDEADBEEF, 1'b0, 64'h0, 2, "b2b-wr");
                applyStimulus(1, 1'b0, 3'd3, BASE1 + 64'h10, 64'h0, 1'b0, 64'hCAFEF00DDEADBEEF, 2, "b2b-rd");
            end
            begin
                @(posedge HCLK);
                checkOutput(1);
                checkOutput(1);
            end
        join
        applyStimulus(1, 1'b0, 3'd3, BASE1 + 64'(DEPTH1), 64'h0, 1'b1, 64'h0, 1, "ws-err-range");
        checkOutput(1);

        // Reset during the wait of a write drops the write.
        sel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3; haddr = BASE1 + 64'h10;
        @(posedge HCLK);
        #1;
        sel1 = 1'b0; htrans = 2'b00; hwdata = 64'h5555AAAA5555AAAA;
        @(negedge HCLK);
        checkValue("rst-wait-ready", 64'(ready1), 64'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkValue("rst-ready", 64'(ready1), 64'd1);
        checkValue("rst-resp", 64'(resp1), 64'd0);
        checkValue("rst-rdata", rdata1, 64'h0);
        @(posedge HCLK);
        #1;
        applyStimulus(1, 1'b0, 3'd3, BASE1 + 64'h10, 64'h0, 1'b0, 64'hCAFEF00DDEADBEEF, 2, "rst-old-rd");
        checkOutput(1);

        checkValue("scoreboard-drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
